// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the fetch stage of the pipelined MIPS core.
// It picks the next PC value for the PC register: the next sequential address, a jump
// target or a branch target. It holds the PC during load-use stalls and while
// instruction memory is not ready. It also drives the IF/ID and ID/EX flush/hold
// controls, flags misaligned redirect targets and counts lost fetch cycles.
//
// Ports:
//   clk            in   pipeline clock, rising-edge state updates
//   rst_n          in   asynchronous active-low reset
//   pc_q           in   current PC register value
//   imem_ready     in   instruction word for pc_q is available this cycle
//   load_use_stall in   hazard unit requests fetch/decode hold
//   jump           in   jump decoded in ID
//   jump_target    in   jump destination
//   branch_taken   in   branch resolved taken in EX
//   branch_target  in   branch destination
//   pc_next        out  value loaded by the PC register when pc_write=1
//   pc_write       out  PC register load enable
//   if_id_write    out  IF/ID load enable (0 = hold)
//   if_id_flush    out  zero IF/ID contents
//   id_ex_flush    out  insert bubble into ID/EX
//   align_err      out  sticky misaligned-target error
//   stall_cnt      out  saturating count of lost fetch cycles
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc_q,
  input  logic             imem_ready,
  input  logic             load_use_stall,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic [31:0]      pc_next,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             align_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_align_err;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [31:0]       w_pc_plus4;
  logic              w_align_set;
  logic              w_count_en;

  // Modulo-2^32 sequential address: 32'hFFFF_FFFC wraps to zero.
  assign w_pc_plus4 = pc_q + 32'd4;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and combinational output decode.
  always_comb begin
    w_state_next = r_state;
    pc_next      = w_pc_plus4;
    pc_write     = 1'b0;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    w_align_set  = 1'b0;
    case (r_state)
      ST_BOOT: begin
        pc_next      = RESET_PC;
        pc_write     = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        // A branch in EX is older than a jump in ID, so it wins and the jump is dropped.
        if (branch_taken) begin
          pc_next     = branch_target;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (branch_target[1:0] != 2'b00) begin
            pc_write     = 1'b0;
            w_align_set  = 1'b1;
            w_state_next = ST_HALT;
          end else begin
            pc_write     = 1'b1;
            w_state_next = ST_REDIRECT;
          end
        end else if (jump) begin
          pc_next     = jump_target;
          if_id_flush = 1'b1;
          if (jump_target[1:0] != 2'b00) begin
            pc_write     = 1'b0;
            id_ex_flush  = 1'b1;
            w_align_set  = 1'b1;
            w_state_next = ST_HALT;
          end else begin
            pc_write     = 1'b1;
            w_state_next = ST_REDIRECT;
          end
        end else if (load_use_stall) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end else if (!imem_ready) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
      end
      ST_REDIRECT: begin
        // Control inputs here come from squashed instructions and are ignored.
        pc_write    = imem_ready;
        if_id_write = imem_ready;
        if (imem_ready) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_REDIRECT;
        end
      end
      ST_HALT: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b1;
        w_state_next = ST_HALT;
      end
      default: begin
        pc_next      = RESET_PC;
        pc_write     = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        w_state_next = ST_BOOT;
      end
    endcase
  end

  // A lost fetch cycle is any RUN/REDIRECT cycle that does not load the PC.
  assign w_count_en = ((r_state == ST_RUN) || (r_state == ST_REDIRECT)) && !pc_write;

  // Sticky alignment error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_align_err <= 1'b0;
    end else if (w_align_set) begin
      r_align_err <= 1'b1;
    end else begin
      r_align_err <= r_align_err;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_count_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign align_err = r_align_err;
  assign stall_cnt = r_stall_cnt;

endmodule
